key_event_arb: RTL and testbench
================================

KEY_EVENT_ARB -- requirements
Module: key_event_arb

Interface
REQ-001 Parameter DEPTH, default 4, event FIFO depth; legal values are 2, 4 and 8.
REQ-002 clk  input  1  system clock, 50 MHz; all logic is rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 key_flag  input  4  one-cycle press pulses, one bit per debounced key; bit i is key i.
REQ-005 enable  input  1  high = accept new key_flag pulses.
REQ-006 evt_valid  output  1  FIFO head holds an event.
REQ-007 evt_ready  input  1  consumer accepts the head event.
REQ-008 evt_id  output  2  key index of the head event.
REQ-009 evt_cnt  output  4  per-key press count (mod 16) carried with the head event.
REQ-010 pend  output  4  pending-request latches, one bit per key.
REQ-011 ovf  output  1  sticky flag: an event was lost.
REQ-012 ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-013 The block SHALL set pend[i] on the clock edge where key_flag[i]=1 and enable=1.
REQ-014 The block SHALL ignore key_flag while enable=0; pend, arbitration and draining SHALL continue.
REQ-015 A key_flag[i] pulse arriving while pend[i] is already 1 and not granted that cycle SHALL set ovf; pend[i] stays 1 (the two presses merge into one event).
REQ-016 Arbitration SHALL run every cycle in which pend!=0 and the FIFO is not full, granting exactly one key.
REQ-017 Arbitration SHALL be round-robin: search starts at last_grant+1 mod 4; last_grant updates on every grant.
REQ-018 On a grant to key i, the block SHALL do the following on the same edge: clear pend[i], increment cnt[i] mod 16, and push {i, cnt[i]+1} into the FIFO.
REQ-019 If key_flag[i]=1 in the same cycle key i is granted, pend[i] SHALL remain 1 and ovf SHALL NOT be set.
REQ-020 No grant SHALL occur while the FIFO holds DEPTH entries, even if a pop occurs that cycle; pending requests wait.
REQ-021 evt_valid SHALL be 1 exactly when the FIFO is non-empty; evt_id and evt_cnt SHALL present the head entry combinationally from storage (first-word fall-through).
REQ-022 A pop SHALL occur on an edge with evt_valid=1 and evt_ready=1.
REQ-023 When empty, evt_id and evt_cnt SHALL read 0 and evt_ready SHALL be ignored.
REQ-024 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-025 The FIFO read and write pointers SHALL wrap modulo DEPTH, with an occupancy counter of width log2(DEPTH)+1.
REQ-026 Latency SHALL be: key_flag high before edge N -> pend set at N -> grant at N+1 -> evt_valid high after N+1, given an empty FIFO and no competing pend.
REQ-027 When cnt[i] is 15, a grant to key i SHALL wrap it to 0; the pushed evt_cnt is 0.
REQ-028 ovf SHALL clear on an edge with ovf_clr=1 unless a new loss event occurs on that same edge, in which case ovf stays 1.
REQ-029 Throughput SHALL be a maximum of one grant and one pop per cycle.

Reset
REQ-030 When rst_n=0, the block SHALL asynchronously force: pend=0, all cnt[i]=0, FIFO empty, pointers=0, evt_valid=0, evt_id=0, evt_cnt=0, ovf=0.
REQ-031 Reset SHALL initialise last_grant=3, so the first search starts at key 0.
REQ-032 Reset asserted mid-operation SHALL discard all queued and pending events; no event SHALL appear after release until a new key_flag pulse.

Verification
REQ-033 Single press: enable=1, key_flag=4'b0100 for one cycle, evt_ready=0 -> evt_valid=1 two edges later, evt_id=2, evt_cnt=1, pend=0.
REQ-034 Simultaneous presses: key_flag=4'b1111 for one cycle after reset, evt_ready=1 -> events popped in order id 0,1,2,3, each with evt_cnt=1, and ovf=0.
REQ-035 Full FIFO: DEPTH=4, evt_ready=0, 6 presses on distinct cycles across keys 0/1 -> 4 entries queued, remaining requests held in pend; releasing evt_ready drains all of them and ovf=0.
REQ-036 Merge and overflow: FIFO full, two pulses on key 3 -> ovf=1 and only one key-3 event is eventually delivered; ovf_clr=1 for one cycle -> ovf=0.
REQ-037 Count wrap: 16 presses on key 1, consumer always ready -> evt_cnt sequence 1..15 then 0.
REQ-038 Disable and reset: enable=0 with key_flag pulses -> no events; queue 3 events, then pulse rst_n low -> evt_valid=0 immediately and stays 0 after release.

Source files
------------

// File: rtl/key_event_arb.sv
// Key press event arbiter: latches one-cycle key pulses and grants them round-robin.
// Each grant pushes {key id, per-key press count} into a first-word fall-through FIFO.
module key_event_arb #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_flag,
  input  logic       enable,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_id,
  output logic [3:0] evt_cnt,
  output logic [3:0] pend,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [3:0]    pend_r;
  logic [1:0]    last_grant_r;
  logic [3:0]    cnt_r [4];
  logic [1:0]    id_mem_r [DEPTH];
  logic [3:0]    cnt_mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          ovf_r;

  logic [3:0]    flag_s;
  logic          full_s;
  logic          empty_s;
  logic          grant_valid_s;
  logic [1:0]    grant_id_s;
  logic [3:0]    grant_s;
  logic [3:0]    grant_cnt_s;
  logic          push_s;
  logic          pop_s;
  logic [3:0]    loss_s;
  logic [3:0]    pend_next_s;

  assign flag_s  = enable ? key_flag : 4'b0000;
  assign full_s  = (count_r == FULL_CNT);
  assign empty_s = (count_r == {CW{1'b0}});

  // Round-robin search from last_grant+1; a full FIFO blocks granting even when popping.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = last_grant_r;
    if (!full_s) begin
      for (int k = 1; k <= 4; k++) begin
        if (!grant_valid_s && pend_r[last_grant_r + 2'(k)]) begin
          grant_valid_s = 1'b1;
          grant_id_s    = last_grant_r + 2'(k);
        end else begin
          grant_valid_s = grant_valid_s;
        end
      end
    end else begin
      grant_valid_s = 1'b0;
    end
  end

  assign grant_s     = grant_valid_s ? (4'b0001 << grant_id_s) : 4'b0000;
  assign grant_cnt_s = cnt_r[grant_id_s] + 4'd1;
  assign push_s      = grant_valid_s;
  assign pop_s       = !empty_s && evt_ready;

  // A fresh pulse on the granted key re-arms pend without counting as a loss.
  assign loss_s      = flag_s & pend_r & ~grant_s;
  assign pend_next_s = (pend_r & ~grant_s) | flag_s;

  // Pending latches, sticky overflow and arbitration history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r       <= 4'b0000;
      ovf_r        <= 1'b0;
      last_grant_r <= 2'd3;
    end else begin
      pend_r <= pend_next_s;
      if (|loss_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
      if (push_s) begin
        last_grant_r <= grant_id_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  // Per-key press counters and FIFO storage/pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= 4'd0;
      end
      for (int j = 0; j < DEPTH; j++) begin
        id_mem_r[j]  <= 2'd0;
        cnt_mem_r[j] <= 4'd0;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        cnt_r[grant_id_s]   <= grant_cnt_s;
        id_mem_r[wr_ptr_r]  <= grant_id_s;
        cnt_mem_r[wr_ptr_r] <= grant_cnt_s;
        wr_ptr_r            <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign evt_valid = !empty_s;
  assign evt_id    = empty_s ? 2'd0 : id_mem_r[rd_ptr_r];
  assign evt_cnt   = empty_s ? 4'd0 : cnt_mem_r[rd_ptr_r];
  assign pend      = pend_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_key_event_arb.sv
// Directed self-checking bench for key_event_arb (DEPTH=4).
module tb_key_event_arb;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_flag;
  logic       enable;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [3:0] evt_cnt;
  logic [3:0] pend;
  logic       ovf;
  logic       ovf_clr;

  int errors = 0;
  int checks = 0;

  key_event_arb #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_flag  (key_flag),
    .enable    (enable),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_cnt   (evt_cnt),
    .pend      (pend),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; key_flag = 4'b0000; enable = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #5;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
    checks++; if (evt_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", evt_id); end
    checks++; if (evt_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", evt_cnt); end
    checks++; if (pend !== 4'b0000) begin errors++; $display("FAIL reset_pend: got %b expected 0000", pend); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_press();
    do_reset();
    key_flag = 4'b0100;
    @(posedge clk); @(negedge clk);
    key_flag = 4'b0000;
    checks++; if (pend !== 4'b0100) begin errors++; $display("FAIL single_pend_set: got %b expected 0100", pend); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early: got %b expected 0", evt_valid); end
    @(posedge clk); @(negedge clk);
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", evt_valid); end
    checks++; if (evt_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d expected 2", evt_id); end
    checks++; if (evt_cnt !== 4'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", evt_cnt); end
    checks++; if (pend !== 4'b0000) begin errors++; $display("FAIL single_pend_clr: got %b expected 0000", pend); end
    evt_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_popped: got %b expected 0", evt_valid); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    key_flag = 4'b1111; evt_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    key_flag = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL simul_valid[%0d]: got %b expected 1", k, evt_valid); end
      checks++; if (evt_id !== 2'(k)) begin errors++; $display("FAIL simul_id[%0d]: got %0d expected %0d", k, evt_id, k); end
      checks++; if (evt_cnt !== 4'd1) begin errors++; $display("FAIL simul_cnt[%0d]: got %0d expected 1", k, evt_cnt); end
    end
    @(posedge clk); @(negedge clk);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL simul_drained: got %b expected 0", evt_valid); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL simul_ovf: got %b expected 0", ovf); end
    evt_ready = 1'b0;
  endtask

  task automatic test_full_fifo();
    logic [1:0] exp_id;
    logic [3:0] exp_cnt;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      key_flag = (k % 2 == 0) ? 4'b0001 : 4'b0010;
      @(posedge clk); @(negedge clk);
    end
    key_flag = 4'b0000;
    @(posedge clk); @(negedge clk);
    checks++; if (pend !== 4'b0011) begin errors++; $display("FAIL full_pend_held: got %b expected 0011", pend); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL full_ovf: got %b expected 0", ovf); end
    evt_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_id  = 2'(k % 2);
      exp_cnt = 4'(k / 2 + 1);
      checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL full_valid[%0d]: got %b expected 1", k, evt_valid); end
      checks++; if (evt_id !== exp_id) begin errors++; $display("FAIL full_id[%0d]: got %0d expected %0d", k, evt_id, exp_id); end
      checks++; if (evt_cnt !== exp_cnt) begin errors++; $display("FAIL full_cnt[%0d]: got %0d expected %0d", k, evt_cnt, exp_cnt); end
      @(posedge clk); @(negedge clk);
    end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL full_drained: got %b expected 0", evt_valid); end
    checks++; if (pend !== 4'b0000) begin errors++; $display("FAIL full_pend_empty: got %b expected 0000", pend); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL full_ovf_end: got %b expected 0", ovf); end
    evt_ready = 1'b0;
  endtask

  task automatic test_merge_ovf();
    logic [1:0] exp_id  [5];
    logic [3:0] exp_cnt [5];
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2; exp_id[3] = 2'd0; exp_id[4] = 2'd3;
    exp_cnt[0] = 4'd1; exp_cnt[1] = 4'd1; exp_cnt[2] = 4'd1; exp_cnt[3] = 4'd2; exp_cnt[4] = 4'd1;
    do_reset();
    key_flag = 4'b0111;
    @(posedge clk); @(negedge clk);
    key_flag = 4'b0001;
    @(posedge clk); @(negedge clk);
    key_flag = 4'b0000;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL merge_grant_same_cycle_ovf: got %b expected 0", ovf); end
    checks++; if (pend !== 4'b0111) begin errors++; $display("FAIL merge_grant_same_cycle_pend: got %b expected 0111", pend); end
    repeat (3) begin @(posedge clk); @(negedge clk); end
    key_flag = 4'b1000;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    key_flag = 4'b0000;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL merge_ovf_set: got %b expected 1", ovf); end
    checks++; if (pend !== 4'b1000) begin errors++; $display("FAIL merge_pend: got %b expected 1000", pend); end
    evt_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL merge_valid[%0d]: got %b expected 1", k, evt_valid); end
      checks++; if (evt_id !== exp_id[k]) begin errors++; $display("FAIL merge_id[%0d]: got %0d expected %0d", k, evt_id, exp_id[k]); end
      checks++; if (evt_cnt !== exp_cnt[k]) begin errors++; $display("FAIL merge_cnt[%0d]: got %0d expected %0d", k, evt_cnt, exp_cnt[k]); end
      @(posedge clk); @(negedge clk);
    end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL merge_single_key3: got %b expected 0", evt_valid); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL merge_ovf_sticky: got %b expected 1", ovf); end
    ovf_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL merge_ovf_clr: got %b expected 0", ovf); end
    evt_ready = 1'b0;
  endtask

  task automatic test_count_wrap();
    logic [3:0] exp_c;
    do_reset();
    evt_ready = 1'b1;
    exp_c = 4'd0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      key_flag = 4'b0010;
      @(posedge clk); @(negedge clk);
      key_flag = 4'b0000;
      @(posedge clk); @(negedge clk);
      exp_c = exp_c + 4'd1;
      checks++; if (evt_id !== 2'd1) begin errors++; $display("FAIL wrap_id[%0d]: got %0d expected 1", k, evt_id); end
      checks++; if (evt_cnt !== exp_c) begin errors++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", k, evt_cnt, exp_c); end
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_disable_reset();
    do_reset();
    enable = 1'b0; key_flag = 4'b1111;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    key_flag = 4'b0000;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    checks++; if (pend !== 4'b0000) begin errors++; $display("FAIL dis_pend: got %b expected 0000", pend); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL dis_valid: got %b expected 0", evt_valid); end
    enable = 1'b1; key_flag = 4'b0111;
    @(posedge clk); @(negedge clk);
    key_flag = 4'b0000;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL dis_queued: got %b expected 1", evt_valid); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", evt_valid); end
    checks++; if (evt_id !== 2'd0) begin errors++; $display("FAIL rst_async_id: got %0d expected 0", evt_id); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_after_valid: got %b expected 0", evt_valid); end
    checks++; if (pend !== 4'b0000) begin errors++; $display("FAIL rst_after_pend: got %b expected 0000", pend); end
  endtask

  initial begin
    rst_n = 1'b0; key_flag = 4'b0000; enable = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0;
    test_reset();
    test_single_press();
    test_simultaneous();
    test_full_fifo();
    test_merge_ovf();
    test_count_wrap();
    test_disable_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
